// File: rtl/serial_sub_311_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_311_pkg
//  Purpose  : Shared state encodings and default width for the bit-serial
//             subtractor.
//  Revision : 1.0  initial release
// ============================================================================
package serial_sub_311_pkg;

    localparam int SUB_W_311 = 8;

    typedef enum logic [1:0] {
        S_IDLE_311  = 2'b00,
        S_SHIFT_311 = 2'b01,
        S_DONE_311  = 2'b10
    } sub_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_sub_311_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_311_if
//  Purpose  : start/busy/done handshake and operand/result bus of the
//             bit-serial subtractor.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_sub_311_if #(
    parameter int WIDTH = 8
);
    logic             start_311;
    logic [WIDTH-1:0] x_311;
    logic [WIDTH-1:0] y_311;
    logic             busy_311;
    logic             done_311;
    logic [WIDTH-1:0] d_311;
    logic             b_311;

    modport master (
        output start_311, x_311, y_311,
        input  busy_311, done_311, d_311, b_311
    );

    modport slave (
        input  start_311, x_311, y_311,
        output busy_311, done_311, d_311, b_311
    );
endinterface
`default_nettype wire

// File: rtl/serial_sub_311_fs.sv
`default_nettype none
// ============================================================================
//  Module   : hs_311 / fs_311
//  Purpose  : Half-subtractor cell and the full subtractor composed from two
//             of them plus an OR on the borrows.
//  Revision : 1.0  initial release
// ============================================================================
module hs_311 (
    input  wire logic x,
    input  wire logic y,
    output logic      d,
    output logic      bout
);
    assign d    = x ^ y;
    assign bout = ~x & y;
endmodule

module fs_311 (
    input  wire logic x,
    input  wire logic y,
    input  wire logic bin,
    output logic      d,
    output logic      bout
);
    logic w_d1;
    logic w_b1;
    logic w_b2;

    hs_311 u_hs0 (.x(x),    .y(y),   .d(w_d1), .bout(w_b1));
    hs_311 u_hs1 (.x(w_d1), .y(bin), .d(d),    .bout(w_b2));

    assign bout = w_b1 | w_b2;
endmodule
`default_nettype wire

// File: rtl/serial_sub_311.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_311
//  Purpose  : Bit-serial WIDTH-bit subtractor, D = X - Y, LSB first, one
//             full-subtractor cell plus a borrow flop.
//  Revision : 1.0  initial release
// ============================================================================
module serial_sub_311
    import serial_sub_311_pkg::*;
#(
    parameter int WIDTH = SUB_W_311
) (
    input  wire logic         clk_311,
    input  wire logic         rst_311,
    serial_sub_311_if.slave   bus
);
    localparam int                 c_cnt_w    = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    sub_state_t         r_state;
    sub_state_t         w_state_nxt;
    logic [WIDTH-1:0]   r_xs;
    logic [WIDTH-1:0]   r_ys;
    logic [WIDTH-1:0]   r_rs;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_bf;
    logic [WIDTH-1:0]   r_d;
    logic               r_b;
    logic               w_diff;
    logic               w_bout;
    logic [WIDTH-1:0]   w_rs_nxt;

    fs_311 u_fs (
        .x    (r_xs[0]),
        .y    (r_ys[0]),
        .bin  (r_bf),
        .d    (w_diff),
        .bout (w_bout)
    );

    assign w_rs_nxt = {w_diff, r_rs[WIDTH-1:1]};

    always_ff @(posedge clk_311) begin
        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        bus.busy_311 = 1'b0;
        bus.done_311 = 1'b0;
        if (rst_311) begin
            w_state_nxt = S_IDLE_311;
        end else begin
            case (r_state)
                S_IDLE_311:  if (bus.start_311) w_state_nxt = S_SHIFT_311;
                S_SHIFT_311: if (r_cnt == c_cnt_last) w_state_nxt = S_DONE_311;
                S_DONE_311:  w_state_nxt = S_IDLE_311;
                default:     w_state_nxt = S_IDLE_311;
            endcase
        end
        // Status flags come straight off the state register only.
        bus.busy_311 = (r_state == S_SHIFT_311) || (r_state == S_DONE_311);
        bus.done_311 = (r_state == S_DONE_311);
    end

    always_ff @(posedge clk_311) begin
        if (rst_311) begin
            r_xs  <= '0;
            r_ys  <= '0;
            r_rs  <= '0;
            r_cnt <= '0;
            r_bf  <= 1'b0;
            r_d   <= '0;
            r_b   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE_311: begin
                    if (bus.start_311) begin
                        r_xs  <= bus.x_311;
                        r_ys  <= bus.y_311;
                        r_rs  <= '0;
                        r_cnt <= '0;
                        r_bf  <= 1'b0;
                    end
                end
                S_SHIFT_311: begin
                    r_rs  <= w_rs_nxt;
                    r_xs  <= r_xs >> 1;
                    r_ys  <= r_ys >> 1;
                    r_bf  <= w_bout;
                    r_cnt <= r_cnt + 1'b1;
                    // Last bit: publish the result including this cycle's diff/borrow.
                    if (r_cnt == c_cnt_last) begin
                        r_d <= w_rs_nxt;
                        r_b <= w_bout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.d_311 = r_d;
    assign bus.b_311 = r_b;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_311.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_sub_311
//  Purpose  : Directed-vector bench for the bit-serial subtractor, WIDTH=8.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_sub_311;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    serial_sub_311_if #(.WIDTH(8)) bus ();

    serial_sub_311 #(.WIDTH(8)) dut (
        .clk_311 (clk),
        .rst_311 (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Start one operation and wait for its done pulse; lat counts edges after E0.
    task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                         output logic [7:0] d, output logic b, output int lat);
        @(negedge clk);
        bus.x_311     = x;
        bus.y_311     = y;
        bus.start_311 = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        bus.start_311 = 1'b0;
        while (!bus.done_311 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        d = bus.d_311;
        b = bus.b_311;
    endtask

    task automatic test_reset();
        bus.start_311 = 1'b1;
        bus.x_311     = 8'h12;
        bus.y_311     = 8'h34;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({bus.busy_311, bus.done_311, bus.d_311, bus.b_311} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b d=%h b=%b, want all 0",
                     bus.busy_311, bus.done_311, bus.d_311, bus.b_311);
        end
        bus.start_311 = 1'b0;
        rst           = 1'b0;
        @(negedge clk);
        n_vec++;
        if (bus.busy_311 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_priority: busy=%b want 0", bus.busy_311);
        end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        logic       b;
        int         lat;
        do_op(8'h5A, 8'h3C, d, b, lat);
        n_vec++;
        if (lat !== 8) begin
            n_err++;
            $display("FAIL basic_latency: got %0d edges want 8", lat);
        end
        n_vec++;
        if ({d, b} !== {8'h1E, 1'b0}) begin
            n_err++;
            $display("FAIL basic_result: d=%h b=%b want d=1e b=0", d, b);
        end
        n_vec++;
        if (bus.busy_311 !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy_in_done: busy=%b want 1", bus.busy_311);
        end
        @(negedge clk);
        n_vec++;
        if ({bus.done_311, bus.busy_311} !== 2'b00) begin
            n_err++;
            $display("FAIL basic_done_pulse: done=%b busy=%b want 0 0",
                     bus.done_311, bus.busy_311);
        end
        n_vec++;
        if (bus.d_311 !== 8'h1E) begin
            n_err++;
            $display("FAIL basic_hold: d=%h want 1e", bus.d_311);
        end
    endtask

    task automatic test_underflow();
        logic [7:0] d;
        logic       b;
        int         lat;
        do_op(8'h00, 8'h01, d, b, lat);
        n_vec++;
        if ({d, b} !== {8'hFF, 1'b1}) begin
            n_err++;
            $display("FAIL underflow_0_1: d=%h b=%b want d=ff b=1", d, b);
        end
        do_op(8'h3C, 8'h5A, d, b, lat);
        n_vec++;
        if ({d, b} !== {8'hE2, 1'b1}) begin
            n_err++;
            $display("FAIL underflow_3c_5a: d=%h b=%b want d=e2 b=1", d, b);
        end
    endtask

    task automatic test_extremes();
        logic [7:0] d;
        logic       b;
        int         lat;
        do_op(8'hFF, 8'hFF, d, b, lat);
        n_vec++;
        if ({d, b} !== {8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL equal_ff: d=%h b=%b want d=00 b=0", d, b);
        end
        do_op(8'h80, 8'h7F, d, b, lat);
        n_vec++;
        if ({d, b} !== {8'h01, 1'b0}) begin
            n_err++;
            $display("FAIL extreme_80_7f: d=%h b=%b want d=01 b=0", d, b);
        end
    endtask

    task automatic test_start_while_busy();
        int n_done = 0;
        int n_0f   = 0;
        @(negedge clk);
        bus.x_311 = 8'h10;
        bus.y_311 = 8'h01;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.done_311) begin
                n_done++;
                if (bus.d_311 === 8'h0F) n_0f++;
                n_vec++;
                if (k == 9 && bus.d_311 !== 8'h0F) begin
                    n_err++;
                    $display("FAIL busy_first_result: d=%h want 0f", bus.d_311);
                end else if (k == 19 && bus.d_311 !== 8'h76) begin
                    n_err++;
                    $display("FAIL busy_second_result: d=%h want 76", bus.d_311);
                end else if (k != 9 && k != 19) begin
                    n_err++;
                    $display("FAIL busy_done_timing: done at cycle %0d want 9 or 19", k);
                end
            end
            if (k == 10) begin
                n_vec++;
                if (bus.busy_311 !== 1'b0) begin
                    n_err++;
                    $display("FAIL busy_idle_gap: busy=%b want 0", bus.busy_311);
                end
            end
            if (k == 3) bus.x_311 = 8'h77;
            bus.start_311 = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        bus.start_311 = 1'b0;
        n_vec++;
        if (n_done !== 2 || n_0f !== 1) begin
            n_err++;
            $display("FAIL busy_done_count: dones=%0d with_0f=%0d want 2 and 1", n_done, n_0f);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_shift();
        logic [7:0] d;
        logic       b;
        int         lat;
        int         n_done = 0;
        @(negedge clk);
        bus.x_311     = 8'h05;
        bus.y_311     = 8'h09;
        bus.start_311 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_311 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({bus.busy_311, bus.d_311, bus.b_311} !== 10'd0) begin
            n_err++;
            $display("FAIL midshift_reset: busy=%b d=%h b=%b want 0 00 0",
                     bus.busy_311, bus.d_311, bus.b_311);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done_311) n_done++;
        end
        n_vec++;
        if (n_done !== 0) begin
            n_err++;
            $display("FAIL midshift_no_done: got %0d done pulses want 0", n_done);
        end
        do_op(8'hC8, 8'h64, d, b, lat);
        n_vec++;
        if ({d, b} !== {8'h64, 1'b0} || lat !== 8) begin
            n_err++;
            $display("FAIL midshift_recover: d=%h b=%b lat=%0d want d=64 b=0 lat=8", d, b, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] d;
        logic [7:0] exp_d;
        logic       b;
        int         lat;
        for (int i = 0; i < 1000; i++) begin
            x     = 8'($urandom_range(0, 255));
            y     = 8'($urandom_range(0, 255));
            exp_d = x - y;
            do_op(x, y, d, b, lat);
            n_vec++;
            if (d !== exp_d || b !== (x < y) || lat !== 8) begin
                n_err++;
                $display("FAIL random_%0d: x=%h y=%h d=%h b=%b lat=%0d want d=%h b=%b lat=8",
                         i, x, y, d, b, lat, exp_d, (x < y));
            end
        end
    endtask

    initial begin
        bus.start_311 = 1'b0;
        bus.x_311     = 8'h00;
        bus.y_311     = 8'h00;
        test_reset();
        test_basic();
        test_underflow();
        test_extremes();
        test_start_while_busy();
        test_reset_mid_shift();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
